// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation codes,
// FSM encoding and the conditional two's-complement helpers.
package muldiv_pkg;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic [31:0] neg32(input logic c, input logic [31:0] v);
      return c ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] neg64(input logic c, input logic [63:0] v);
      return c ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between control and the multiply/divide unit.
// start is sampled only while busy is low; result_valid is a single-cycle write strobe.
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            busy;
   logic            result_valid;
   logic [XLEN-1:0] result;
   logic [4:0]      result_rd;
   state_t          dbg_state;

   modport master (
      output start, funct3, op_a, op_b, rd_in,
      input  busy, result_valid, result, result_rd, dbg_state
   );

   modport slave (
      input  start, funct3, op_a, op_b, rd_in,
      output busy, result_valid, result, result_rd, dbg_state
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes sharing one 64-bit work register, with sign fix-up at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input logic     clk,
   input logic     reset,
   muldiv_if.slave bus
);

   state_t            state;
   logic [4:0]        counter;
   logic [2:0]        op;
   logic [4:0]        rd_q;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] work;
   logic              spec_hit;
   logic [XLEN-1:0]   spec_val;

   logic              a_signed, b_signed, s_a, s_b;
   logic              div_zero, sovf, special;
   logic [XLEN-1:0]   mag_a, mag_b, special_res;
   logic [XLEN:0]     sum;
   logic [2*XLEN:0]   shifted;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] work_next, prod;
   logic [XLEN-1:0]   quo, rem, fix_res;

   assign bus.busy      = (state != S_IDLE);
   assign bus.dbg_state = state;

   always_comb begin
      a_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                 (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
      b_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
                 (bus.funct3 == F3_REM);
      s_a      = a_signed & bus.op_a[XLEN-1];
      s_b      = b_signed & bus.op_b[XLEN-1];
      mag_a    = neg32(s_a, bus.op_a);
      mag_b    = neg32(s_b, bus.op_b);
      div_zero = bus.funct3[2] && (bus.op_b == '0);
      // funct3[0]==0 selects the signed divide forms (DIV, REM)
      sovf     = bus.funct3[2] && !bus.funct3[0] &&
                 (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
      special  = div_zero || sovf;
      if (div_zero)
         special_res = bus.funct3[1] ? bus.op_a : '1;
      else
         special_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   always_comb begin
      sum     = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, opnd};
      shifted = {work, 1'b0};
      diff    = shifted[2*XLEN:XLEN] - {1'b0, opnd};
      if (op[2]) begin
         // Keep the trial subtraction only when it did not borrow
         work_next = diff[XLEN] ? shifted[2*XLEN-1:0]
                                : {diff[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
      end else begin
         work_next = work[0] ? {sum, work[XLEN-1:1]} : {1'b0, work[2*XLEN-1:1]};
      end
      prod = neg64(sign_a ^ sign_b, work_next);
      quo  = neg32(sign_a ^ sign_b, work_next[XLEN-1:0]);
      rem  = neg32(sign_a, work_next[2*XLEN-1:XLEN]);
      case (op)
         F3_MUL:                        fix_res = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               fix_res = quo;
         default:                       fix_res = rem;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         counter          <= '0;
         op               <= '0;
         rd_q             <= '0;
         sign_a           <= 1'b0;
         sign_b           <= 1'b0;
         opnd             <= '0;
         work             <= '0;
         spec_hit         <= 1'b0;
         spec_val         <= '0;
         bus.result_valid <= 1'b0;
         bus.result       <= '0;
         bus.result_rd    <= '0;
      end else begin
         // The write strobe fires in the cycle after DONE, as the unit returns to IDLE
         bus.result_valid <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op       <= bus.funct3;
                  rd_q     <= bus.rd_in;
                  sign_a   <= s_a;
                  sign_b   <= s_b;
                  opnd     <= bus.funct3[2] ? mag_b : mag_a;
                  work     <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
                  counter  <= '0;
                  spec_hit <= special;
                  spec_val <= special_res;
                  if (EARLY_OUT && special) begin
                     state         <= S_DONE;
                     bus.result    <= special_res;
                     bus.result_rd <= bus.rd_in;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               work    <= work_next;
               counter <= counter + 5'd1;
               if (counter == 5'd31) begin
                  state         <= S_DONE;
                  bus.result    <= spec_hit ? spec_val : fix_res;
                  bus.result_rd <= rd_q;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
